// File: rtl/case_decode_pkg.sv
// Shared types and helpers for the registered case decoder.
// Holds the FSM state encoding, parameter defaults and the table lookup.
package case_decode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEFAULT_VAL_DEF = 5;
   localparam int STEP_CYCLES_DEF = 10;
   localparam int LUT_W = 32;

   // Result is {hit, value}; callers slice value down to their data width.
   function automatic logic [LUT_W:0] lookup(
      input logic             vld,
      input logic [LUT_W-1:0] data,
      input logic [LUT_W-1:0] dflt
   );
      return vld ? {1'b1, data} : {1'b0, dflt};
   endfunction

endpackage

// File: rtl/case_step_timer.sv
// Modulo-STEP_CYCLES step timer with clear and enable.
// Flags the first and last cycle of each step.
module case_step_timer
   import case_decode_pkg::*;
#(
   parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_first,
   output logic o_last
);

   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_last ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_first = (r_cnt == '0);
   assign o_last  = (r_cnt == LAST);

endmodule

// File: rtl/case_decode_seq.sv
// Registered, programmable select-code decoder with a direct lookup
// mode and an auto-sequence mode that steps through codes 0..seq_last.
module case_decode_seq
   import case_decode_pkg::*;
#(
   parameter int SEL_W       = 3,
   parameter int DATA_W      = 4,
   parameter int DEFAULT_VAL = DEFAULT_VAL_DEF,
   parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_clr,
   input  logic              mode,
   input  logic              sel_valid,
   input  logic [SEL_W-1:0]  sel_in,
   output logic              sel_ready,
   input  logic              start,
   input  logic [SEL_W-1:0]  seq_last,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_hit,
   output logic              busy
);

   localparam int DEPTH = 2 ** SEL_W;
   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] SEQ  = ST_SEQ;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_tbl [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [SEL_W-1:0]  r_code;
   logic [SEL_W-1:0]  r_last;

   logic             w_in_seq;
   logic             w_acc;
   logic             w_start;
   logic             w_first;
   logic             w_last;
   logic [SEL_W-1:0] w_code;
   logic [LUT_W:0]   w_lk;
   logic             w_unused_lk;

   assign w_in_seq  = (r_state == SEQ);
   assign sel_ready = (r_state == IDLE) && !mode;
   assign busy      = w_in_seq;
   assign w_acc     = sel_valid && sel_ready;
   assign w_start   = (r_state == IDLE) && mode && start;
   assign w_code    = w_in_seq ? r_code : sel_in;

   // Reads see the table as it stood before this edge's write.
   assign w_lk = lookup(r_vld[w_code],
                        LUT_W'(r_tbl[w_code]),
                        LUT_W'(DEFAULT_VAL));
   assign w_unused_lk = ^w_lk[LUT_W-1:DATA_W];

   case_step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (!w_in_seq),
      .i_en   (w_in_seq),
      .o_first(w_first),
      .o_last (w_last)
   );

   always_ff @(posedge clk) begin
      if (cfg_we) begin
         r_tbl[cfg_addr] <= cfg_data;
      end
   end

   // Clear first, then the write, so a same-edge write survives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else begin
         if (cfg_clr) r_vld <= '0;
         if (cfg_we)  r_vld[cfg_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_code    <= '0;
         r_last    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         out_hit   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= SEQ;
                  r_code  <= '0;
                  r_last  <= seq_last;
               end
            end
            SEQ: begin
               if (w_last) begin
                  if (r_code == r_last) r_state <= DONE;
                  else                  r_code  <= r_code + SEL_W'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_acc || (w_in_seq && w_first)) begin
            out_valid <= 1'b1;
            out_data  <= w_lk[DATA_W-1:0];
            out_sel   <= w_code;
            out_hit   <= w_lk[LUT_W];
         end
      end
   end

endmodule

// File: tb/tb_case_decode_seq.sv
// Scoreboard bench for case_decode_seq: expected pulses are queued
// when stimulus is driven and popped when out_valid appears.
module tb_case_decode_seq;

   localparam int SEL_W = 3;
   localparam int DATA_W = 4;
   localparam int STEP = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              cfg_we;
   logic [SEL_W-1:0]  cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_clr;
   logic              mode;
   logic              sel_valid;
   logic [SEL_W-1:0]  sel_in;
   logic              sel_ready;
   logic              start;
   logic [SEL_W-1:0]  seq_last;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_sel;
   logic              out_hit;
   logic              busy;

   case_decode_seq #(
      .SEL_W      (SEL_W),
      .DATA_W     (DATA_W),
      .DEFAULT_VAL(5),
      .STEP_CYCLES(STEP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_clr  (cfg_clr),
      .mode     (mode),
      .sel_valid(sel_valid),
      .sel_in   (sel_in),
      .sel_ready(sel_ready),
      .start    (start),
      .seq_last (seq_last),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_sel  (out_sel),
      .out_hit  (out_hit),
      .busy     (busy)
   );

   typedef struct {
      logic [2:0] sel;
      logic [3:0] data;
      logic       hit;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       m_e;
   logic [3:0] m_tbl[8];
   logic [7:0] m_vld;
   int         cyc = 0;
   int         errs = 0;
   int         chks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [2:0] c, input int at);
      exp_t e;
      e.sel  = c;
      e.data = m_vld[c] ? m_tbl[c] : 4'd5;
      e.hit  = m_vld[c];
      e.cyc  = at;
      return e;
   endfunction

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         chks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_pulse: sel=%0d data=%0d cyc=%0d, required no pulse",
                     out_sel, out_data, cyc);
         end else begin
            m_e = q.pop_front();
            if (out_sel !== m_e.sel || out_data !== m_e.data ||
                out_hit !== m_e.hit || cyc != m_e.cyc) begin
               errs++;
               $display("FAIL pulse: got sel=%0d data=%0d hit=%0d cyc=%0d, required sel=%0d data=%0d hit=%0d cyc=%0d",
                        out_sel, out_data, out_hit, cyc,
                        m_e.sel, m_e.data, m_e.hit, m_e.cyc);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_clr = 1'b0;
      mode = 1'b0; sel_valid = 1'b0; sel_in = '0;
      start = 1'b0; seq_last = '0;
      m_vld = '0;
      repeat (2) tick();
      @(negedge clk);
      chks++;
      if ({out_valid, out_data, out_sel, out_hit, busy} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got v=%b d=%0d s=%0d h=%b busy=%b, required all 0",
                  out_valid, out_data, out_sel, out_hit, busy);
      end
      chks++;
      if (sel_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_ready: got %b, required 1", sel_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_direct_default;
      logic [2:0] codes[4] = '{3'd0, 3'd1, 3'd5, 3'd6};
      foreach (codes[i]) begin
         sel_valid = 1'b1;
         sel_in = codes[i];
         q.push_back(mk(codes[i], cyc + 1));
         tick();
      end
      sel_valid = 1'b0;
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_default: %0d pulses missing, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_direct_programmed;
      logic [2:0] wa[3] = '{3'd0, 3'd1, 3'd5};
      logic [3:0] wd[3] = '{4'd9, 4'd2, 4'd1};
      logic [2:0] codes[4] = '{3'd0, 3'd1, 3'd5, 3'd6};
      foreach (wa[i]) begin
         cfg_we = 1'b1; cfg_addr = wa[i]; cfg_data = wd[i];
         tick();
         m_tbl[wa[i]] = wd[i];
         m_vld[wa[i]] = 1'b1;
      end
      cfg_we = 1'b0;
      foreach (codes[i]) begin
         sel_valid = 1'b1;
         sel_in = codes[i];
         q.push_back(mk(codes[i], cyc + 1));
         tick();
      end
      sel_valid = 1'b0;
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_programmed: %0d pulses missing, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_auto;
      int  n;
      logic eb;
      mode = 1'b1;
      seq_last = 3'd3;
      tick();
      @(negedge clk);
      chks++;
      if (sel_ready !== 1'b0) begin
         errs++;
         $display("FAIL auto_ready: got %b, required 0", sel_ready);
      end
      tick();
      start = 1'b1;
      n = cyc;
      for (int i = 0; i < 4; i++) q.push_back(mk(3'(i), n + 2 + STEP * i));
      tick();
      start = 1'b0;
      sel_valid = 1'b1;
      sel_in = 3'd2;
      for (int k = 0; k < 50; k++) begin
         start = (cyc == n + 15);
         @(negedge clk);
         eb = (cyc >= n + 1) && (cyc <= n + 40);
         chks++;
         if (busy !== eb) begin
            errs++;
            $display("FAIL auto_busy: cyc=%0d got %b, required %b", cyc - n, busy, eb);
         end
         tick();
      end
      start = 1'b0;
      sel_valid = 1'b0;
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_auto: %0d pulses missing, required 0", q.size());
         q.delete();
      end
      mode = 1'b0;
      tick();
      @(negedge clk);
      chks++;
      if (sel_ready !== 1'b1) begin
         errs++;
         $display("FAIL auto_idle_ready: got %b, required 1", sel_ready);
      end
   endtask

   task automatic test_same_cycle;
      logic [2:0] codes[3] = '{3'd0, 3'd3, 3'd1};
      tick();
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 4'd7;
      sel_valid = 1'b1; sel_in = 3'd1;
      q.push_back(mk(3'd1, cyc + 1));
      m_tbl[1] = 4'd7;
      m_vld[1] = 1'b1;
      tick();
      cfg_we = 1'b0;
      q.push_back(mk(3'd1, cyc + 1));
      tick();
      sel_valid = 1'b0;
      cfg_clr = 1'b1;
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 4'd12;
      tick();
      m_vld = '0;
      m_vld[3] = 1'b1;
      m_tbl[3] = 4'd12;
      cfg_clr = 1'b0;
      cfg_we = 1'b0;
      foreach (codes[i]) begin
         sel_valid = 1'b1;
         sel_in = codes[i];
         q.push_back(mk(codes[i], cyc + 1));
         tick();
      end
      sel_valid = 1'b0;
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_same_cycle: %0d pulses missing, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset_mid_seq;
      int n;
      for (int i = 0; i < 8; i++) begin
         cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 4'(15 - i);
         tick();
         m_tbl[i] = 4'(15 - i);
         m_vld[i] = 1'b1;
      end
      cfg_we = 1'b0;
      mode = 1'b1;
      seq_last = 3'd7;
      start = 1'b1;
      n = cyc;
      for (int i = 0; i < 3; i++) q.push_back(mk(3'(i), n + 2 + STEP * i));
      tick();
      start = 1'b0;
      while (cyc < n + 25) tick();
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chks++;
      if ({out_valid, out_data, out_sel, out_hit, busy} !== '0) begin
         errs++;
         $display("FAIL mid_reset_outputs: got v=%b d=%0d s=%0d h=%b busy=%b, required all 0",
                  out_valid, out_data, out_sel, out_hit, busy);
      end
      m_vld = '0;
      rst_n = 1'b1;
      mode = 1'b0;
      repeat (30) tick();
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_mid_reset: %0d pulses missing, required 0", q.size());
         q.delete();
      end
      sel_valid = 1'b1;
      sel_in = 3'd5;
      q.push_back(mk(3'd5, cyc + 1));
      tick();
      sel_valid = 1'b0;
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_after_reset: %0d pulses missing, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_full_seq;
      int   n;
      logic eb;
      for (int i = 0; i < 8; i++) begin
         cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 4'((i * 3 + 1) & 15);
         tick();
         m_tbl[i] = 4'((i * 3 + 1) & 15);
         m_vld[i] = 1'b1;
      end
      cfg_we = 1'b0;
      mode = 1'b1;
      seq_last = 3'd7;
      start = 1'b1;
      n = cyc;
      for (int i = 0; i < 8; i++) q.push_back(mk(3'(i), n + 2 + STEP * i));
      tick();
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         eb = (cyc >= n + 1) && (cyc <= n + 80);
         chks++;
         if (busy !== eb) begin
            errs++;
            $display("FAIL full_busy: cyc=%0d got %b, required %b", cyc - n, busy, eb);
         end
         tick();
      end
      chks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain_full: %0d pulses missing, required 0", q.size());
         q.delete();
      end
      mode = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_direct_default();
      test_direct_programmed();
      test_auto();
      test_same_cycle();
      test_reset_mid_seq();
      test_full_seq();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
